led_scan_receiver: RTL and testbench

Receive side of the 8x8 bicolour LED matrix scan interface. Samples the multiplexed row-sink and red/green column-drive lines, one row at a time, as driven by the matrix driver over GPIO. Rebuilds complete red and green frames and publishes each frame with a one-cycle strobe. Used on a second board as a remote display mirror and in self-test loopback of the game's GPIO header. Also flags malformed scans.

---
 rtl/led_scan_receiver.sv | 187 ++++++++++++++++++
 tb/tb_led_scan_receiver.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led_scan_receiver.sv
// Rebuilds 8x8 red/green LED frames from a multiplexed row scan; flags multi-row scans and counts dropped frames.
// Latency: pin to s is SYNC_STAGES cycles; a row is captured after SETTLE_CYCLES stable cycles of s; the commit is registered one cycle later.
// Backpressure: none. This is a passive sampler, and frame_valid is a one-cycle strobe. Optional macro LED_SCAN_OVERLAP_EN enables the overlap flag.
module led_scan_receiver #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  row_sink,
  input  logic [7:0]  red_driver,
  input  logic [7:0]  green_driver,
  output logic [63:0] red_frame,
  output logic [63:0] green_frame,
  output logic        frame_valid,
  output logic        row_error,
  output logic [7:0]  drop_count,
  output logic        overlap
);

  // The synchronizer comes out of reset showing an idle bus (all rows off).
  // This prevents an all-low row field from being mistaken for a multi-row scan.
  localparam logic [23:0] IDLE   = {8'hFF, 16'h0000};
  localparam logic [7:0]  SETTLE = 8'(SETTLE_CYCLES);

  typedef enum logic {HUNT, ASSEMBLE} state_t;

  logic [23:0] sync_q [SYNC_STAGES];
  logic [23:0] s;
  logic [7:0]  s_row, s_red, s_green;
  logic [23:0] prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        diff, capture;
  logic [3:0]  n_low;
  logic [2:0]  row_idx;
  state_t      state_q, state_d;
  logic [7:0]  seen_q, seen_d;
  logic [63:0] shadow_red_q, shadow_red_d;
  logic [63:0] shadow_green_q, shadow_green_d;
  logic        commit, drop, err_set;
  logic [63:0] red_frame_q, green_frame_q;
  logic        frame_valid_q, row_error_q;
  logic [7:0]  drop_count_q;

  assign s       = sync_q[SYNC_STAGES-1];
  assign s_row   = s[23:16];
  assign s_red   = s[15:8];
  assign s_green = s[7:0];

  // Synchronizer chain for the full 24-bit pin vector.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= IDLE;
    end else begin
      sync_q[0] <= {row_sink, red_driver, green_driver};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Stability counter: restarts at 1 on any change and saturates at SETTLE.
  // A capture fires only in the cycle the count first arrives at SETTLE.
  always_comb begin
    diff = (s != prev_q);
    if (diff)                cnt_d = 8'd1;
    else if (cnt_q >= SETTLE) cnt_d = SETTLE;
    else                     cnt_d = cnt_q + 8'd1;
    capture = (cnt_d == SETTLE) && (diff || (cnt_q != SETTLE));
  end

  // Register the previous sample and the dwell count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q <= IDLE;
      cnt_q  <= 8'd0;
    end else begin
      prev_q <= s;
      cnt_q  <= cnt_d;
    end
  end

  // Count the low row_sink bits and remember which row was selected.
  always_comb begin
    n_low   = 4'd0;
    row_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!s_row[i]) begin
        n_low   = n_low + 4'd1;
        row_idx = 3'(i);
      end
    end
  end

  // Frame assembly state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= HUNT;
      seen_q         <= 8'h00;
      shadow_red_q   <= 64'h0;
      shadow_green_q <= 64'h0;
    end else begin
      state_q        <= state_d;
      seen_q         <= seen_d;
      shadow_red_q   <= shadow_red_d;
      shadow_green_q <= shadow_green_d;
    end
  end

  // Next state: classify each capture and decide whether to write, commit, drop or abort.
  always_comb begin
    state_d        = state_q;
    seen_d         = seen_q;
    shadow_red_d   = shadow_red_q;
    shadow_green_d = shadow_green_q;
    commit         = 1'b0;
    drop           = 1'b0;
    err_set        = 1'b0;
    if (capture && (n_low > 4'd1)) begin
      err_set = 1'b1;
      seen_d  = 8'h00;
      state_d = HUNT;
    end else if (capture && (n_low == 4'd1)) begin
      case (state_q)
        HUNT: begin
          if (row_idx == 3'd0) begin
            shadow_red_d[7:0]   = s_red;
            shadow_green_d[7:0] = s_green;
            seen_d              = 8'h01;
            state_d             = ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          shadow_red_d[{row_idx, 3'b000} +: 8]   = s_red;
          shadow_green_d[{row_idx, 3'b000} +: 8] = s_green;
          if (row_idx == 3'd0) begin
            // Row 0 closes the current frame and opens the next one.
            if (seen_q == 8'hFF) commit = 1'b1;
            else                 drop   = 1'b1;
            seen_d = 8'h01;
          end else begin
            seen_d[row_idx] = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Published frame, strobe, sticky error and saturating drop counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      red_frame_q   <= 64'h0;
      green_frame_q <= 64'h0;
      frame_valid_q <= 1'b0;
      row_error_q   <= 1'b0;
      drop_count_q  <= 8'd0;
    end else begin
      frame_valid_q <= commit;
      if (commit) begin
        red_frame_q   <= shadow_red_q;
        green_frame_q <= shadow_green_q;
      end
      if (err_set) row_error_q <= 1'b1;
      if (drop && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 8'd1;
    end
  end

`ifdef LED_SCAN_OVERLAP_EN
  logic overlap_q;

  // Flag red/green coincidence in the frame being committed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      overlap_q <= 1'b0;
    else if (commit) overlap_q <= |(shadow_red_q & shadow_green_q);
  end

  assign overlap = overlap_q;
`else
  assign overlap = 1'b0;
`endif

  assign red_frame   = red_frame_q;
  assign green_frame = green_frame_q;
  assign frame_valid = frame_valid_q;
  assign row_error   = row_error_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_led_scan_receiver.sv
// Directed bench for led_scan_receiver using default parameters (SETTLE_CYCLES=4, SYNC_STAGES=2).
// Latency: each row is held 8 cycles and followed by 2 blank cycles; checks run after the pipeline has settled.
// Backpressure: none; frame_valid pulses are counted on the falling edge.
module tb_led_scan_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  row_sink, red_driver, green_driver;
  logic [63:0] red_frame, green_frame;
  logic        frame_valid, row_error, overlap;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;
  int fv_cnt = 0;

`ifdef LED_SCAN_OVERLAP_EN
  localparam logic OVL_EXP = 1'b1;
`else
  localparam logic OVL_EXP = 1'b0;
`endif

  always #5 clock = ~clock;

  always @(negedge clock) if (frame_valid === 1'b1) fv_cnt++;

  led_scan_receiver dut (
    .clock(clock), .reset(reset),
    .row_sink(row_sink), .red_driver(red_driver), .green_driver(green_driver),
    .red_frame(red_frame), .green_frame(green_frame), .frame_valid(frame_valid),
    .row_error(row_error), .drop_count(drop_count), .overlap(overlap)
  );

  task automatic hold(input logic [7:0] rs, input logic [7:0] r, input logic [7:0] g, input int n);
    row_sink = rs; red_driver = r; green_driver = g;
    repeat (n) @(negedge clock);
  endtask

  task automatic scan_row(input int i, input logic [7:0] r, input logic [7:0] g);
    logic [7:0] rs;
    rs = ~(8'h01 << i);
    hold(rs, r, g, 8);
    hold(8'hFF, 8'h00, 8'h00, 2);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    hold(8'hFF, 8'h00, 8'h00, 3);
    checks++; if (red_frame !== 64'h0) begin errors++; $display("FAIL reset_red: got %h want 0", red_frame); end
    checks++; if (green_frame !== 64'h0) begin errors++; $display("FAIL reset_green: got %h want 0", green_frame); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    checks++; if (row_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", row_error); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL reset_ovl: got %b want 0", overlap); end
    reset = 1'b1;
    hold(8'hFF, 8'h00, 8'h00, 2);
  endtask

  task automatic test_clean_frame;
    int fv0;
    fv0 = fv_cnt;
    for (int i = 0; i < 8; i++) scan_row(i, 8'h01 << i, 8'h00);
    scan_row(0, 8'h01, 8'h00);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL clean_fv: got %0d pulses want 1", fv_cnt - fv0); end
    checks++; if (red_frame !== 64'h8040201008040201) begin errors++; $display("FAIL clean_red: got %h want 8040201008040201", red_frame); end
    checks++; if (green_frame !== 64'h0) begin errors++; $display("FAIL clean_green: got %h want 0", green_frame); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL clean_drop: got %0d want 0", drop_count); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL clean_ovl: got %b want 0", overlap); end
  endtask

  task automatic test_incomplete;
    int fv0;
    fv0 = fv_cnt;
    scan_row(1, 8'h00, 8'h00);
    scan_row(2, 8'h00, 8'h00);
    scan_row(0, 8'hFF, 8'h00);
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL incomplete_fv: got %0d pulses want 0", fv_cnt - fv0); end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL incomplete_drop: got %0d want 1", drop_count); end
    for (int i = 1; i < 8; i++) scan_row(i, 8'h00, 8'h01 << i);
    scan_row(0, 8'h00, 8'h00);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL recover_fv: got %0d pulses want 1", fv_cnt - fv0); end
    checks++; if (red_frame !== 64'h00000000000000FF) begin errors++; $display("FAIL recover_red: got %h want 00000000000000ff", red_frame); end
    checks++; if (green_frame !== 64'h8040201008040200) begin errors++; $display("FAIL recover_green: got %h want 8040201008040200", green_frame); end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL recover_drop: got %0d want 1", drop_count); end
  endtask

  task automatic test_glitch;
    int fv0;
    fv0 = fv_cnt;
    scan_row(1, 8'hEE, 8'h00);
    scan_row(2, 8'hEE, 8'h00);
    hold(8'b1111_0111, 8'hEE, 8'h00, 3);
    hold(8'hFF, 8'h00, 8'h00, 2);
    for (int i = 4; i < 8; i++) scan_row(i, 8'hEE, 8'h00);
    scan_row(0, 8'h00, 8'h00);
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL glitch_fv: got %0d pulses want 0", fv_cnt - fv0); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL glitch_drop: got %0d want 2", drop_count); end
    checks++; if (red_frame !== 64'h00000000000000FF) begin errors++; $display("FAIL glitch_red: got %h want 00000000000000ff", red_frame); end
  endtask

  task automatic test_multi_row;
    int fv0;
    fv0 = fv_cnt;
    hold(8'b1111_1100, 8'h00, 8'h00, 10);
    hold(8'hFF, 8'h00, 8'h00, 2);
    checks++; if (row_error !== 1'b1) begin errors++; $display("FAIL multi_err: got %b want 1", row_error); end
    scan_row(0, 8'h3C, 8'h00);
    for (int i = 1; i < 8; i++) scan_row(i, 8'h00, 8'hC3);
    scan_row(0, 8'h10, 8'h10);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL multi_fv: got %0d pulses want 1", fv_cnt - fv0); end
    checks++; if (red_frame !== 64'h000000000000003C) begin errors++; $display("FAIL multi_red: got %h want 000000000000003c", red_frame); end
    checks++; if (green_frame !== 64'hC3C3C3C3C3C3C300) begin errors++; $display("FAIL multi_green: got %h want c3c3c3c3c3c3c300", green_frame); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL multi_drop: got %0d want 2", drop_count); end
    checks++; if (row_error !== 1'b1) begin errors++; $display("FAIL multi_sticky: got %b want 1", row_error); end
  endtask

  task automatic test_overlap;
    int fv0;
    fv0 = fv_cnt;
    for (int i = 1; i < 8; i++) scan_row(i, 8'h00, 8'h00);
    scan_row(0, 8'h00, 8'h00);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL ovl_fv: got %0d pulses want 1", fv_cnt - fv0); end
    checks++; if (red_frame !== 64'h10) begin errors++; $display("FAIL ovl_red: got %h want 10", red_frame); end
    checks++; if (green_frame !== 64'h10) begin errors++; $display("FAIL ovl_green: got %h want 10", green_frame); end
    checks++; if (overlap !== OVL_EXP) begin errors++; $display("FAIL ovl_set: got %b want %b", overlap, OVL_EXP); end
    for (int i = 1; i < 8; i++) scan_row(i, 8'h00, 8'h00);
    scan_row(0, 8'h00, 8'h00);
    checks++; if (fv_cnt - fv0 !== 2) begin errors++; $display("FAIL ovl_fv2: got %0d pulses want 2", fv_cnt - fv0); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL ovl_clear: got %b want 0", overlap); end
  endtask

  task automatic test_reset_mid_frame;
    int fv0;
    for (int i = 1; i < 4; i++) scan_row(i, 8'h77, 8'h00);
    hold(8'b1110_1111, 8'h77, 8'h00, 3);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (red_frame !== 64'h0) begin errors++; $display("FAIL midrst_red: got %h want 0", red_frame); end
    checks++; if (green_frame !== 64'h0) begin errors++; $display("FAIL midrst_green: got %h want 0", green_frame); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL midrst_fv: got %b want 0", frame_valid); end
    checks++; if (row_error !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", row_error); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL midrst_drop: got %0d want 0", drop_count); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL midrst_ovl: got %b want 0", overlap); end
    reset = 1'b1;
    hold(8'hFF, 8'h00, 8'h00, 2);
    fv0 = fv_cnt;
    for (int i = 5; i < 8; i++) scan_row(i, 8'h99, 8'h00);
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL hunt_fv: got %0d pulses want 0", fv_cnt - fv0); end
    checks++; if (red_frame !== 64'h0) begin errors++; $display("FAIL hunt_red: got %h want 0", red_frame); end
    for (int i = 0; i < 8; i++) scan_row(i, 8'h55, 8'hAA);
    scan_row(0, 8'h00, 8'h00);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL post_fv: got %0d pulses want 1", fv_cnt - fv0); end
    checks++; if (red_frame !== 64'h5555555555555555) begin errors++; $display("FAIL post_red: got %h want 5555555555555555", red_frame); end
    checks++; if (green_frame !== 64'hAAAAAAAAAAAAAAAA) begin errors++; $display("FAIL post_green: got %h want aaaaaaaaaaaaaaaa", green_frame); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL post_ovl: got %b want 0", overlap); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL post_drop: got %0d want 0", drop_count); end
    checks++; if (row_error !== 1'b0) begin errors++; $display("FAIL post_err: got %b want 0", row_error); end
  endtask

  initial begin
    reset        = 1'b0;
    row_sink     = 8'hFF;
    red_driver   = 8'h00;
    green_driver = 8'h00;
    @(negedge clock);
    test_reset();
    test_clean_frame();
    test_incomplete();
    test_glitch();
    test_multi_row();
    test_overlap();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
